chacha_keystream_engine: RTL and testbench

Parametrised ChaCha block engine that produces a run of consecutive keystream blocks from one key, nonce and starting counter. It builds the 4x4 state matrix, iterates ROUNDS half-rounds, applies the feed-forward addition, and presents each 512-bit block on a valid/ready port. It supports multi-block requests, backpressure, reduced-round variants and counter-overflow detection. It feeds the serializer/XOR stage and replaces the single-block, fixed-round controller in the AEAD datapath.

---
 rtl/chacha_keystream_engine.sv | 186 ++++++++++++++++++
 tb/tb_chacha_keystream_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_keystream_engine.sv
// ChaCha keystream engine: builds the 4x4 state matrix from a latched key,
// nonce and counter, runs ROUNDS half-rounds (one per cycle), applies the
// feed-forward addition and presents each 512-bit block on a valid/ready port.
// Multi-block requests step the counter; stepping past 0xFFFFFFFF is refused
// and reported through the sticky ctr_overflow flag.
//
// Handshake: ks_valid rises when a block is ready and stays high, with ks_data
// and ks_counter frozen, until an edge on which ks_ready=1; that edge is the
// transfer and ks_valid drops on it.
module chacha_keystream_engine #(
  parameter int ROUNDS = 20,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [255:0]      key,
  input  logic [95:0]       nonce,
  input  logic [31:0]       init_counter,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              busy,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [511:0]      ks_data,
  output logic [31:0]       ks_counter,
  output logic              done,
  output logic              ctr_overflow,
  output logic [2:0]        dbg_state
);

  localparam int RW = $clog2(ROUNDS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_ADD, S_OUT} state_t;

  state_t           r_state;
  logic [255:0]     r_key;
  logic [95:0]      r_nonce;
  logic [31:0]      r_counter;
  logic [CNT_W-1:0] r_remaining;
  logic [RW-1:0]    r_round;
  logic [31:0]      r_work [16];
  logic             r_busy;
  logic             r_valid;
  logic [511:0]     r_data;
  logic [31:0]      r_ks_counter;
  logic             r_done;
  logic             r_ovf;

  logic [31:0]      w_init [16];
  logic [31:0]      w_next [16];
  logic [127:0]     w_q;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i + b_i; d = rotl(d_i ^ a, 16);
    c = c_i + d;   b = rotl(b_i ^ c, 12);
    a = a + b;     d = rotl(d ^ a, 8);
    c = c + d;     b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Initial matrix from the latched request. The latched inputs are constant
  // for the life of a block, so this also serves as the feed-forward operand.
  always_comb begin
    w_init[0] = 32'h61707865;
    w_init[1] = 32'h3320646e;
    w_init[2] = 32'h79622d32;
    w_init[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) w_init[4+i] = r_key[32*i +: 32];
    w_init[12] = r_counter;
    for (int i = 0; i < 3; i++) w_init[13+i] = r_nonce[32*i +: 32];
  end

  // One half-round: column round on even steps, diagonal round on odd steps.
  always_comb begin
    w_q = '0;
    for (int i = 0; i < 16; i++) w_next[i] = r_work[i];
    for (int i = 0; i < 4; i++) begin
      if (!r_round[0]) begin
        w_q = qr(r_work[i], r_work[4+i], r_work[8+i], r_work[12+i]);
        w_next[i]    = w_q[127:96];
        w_next[4+i]  = w_q[95:64];
        w_next[8+i]  = w_q[63:32];
        w_next[12+i] = w_q[31:0];
      end else begin
        w_q = qr(r_work[i], r_work[4+((i+1)%4)], r_work[8+((i+2)%4)], r_work[12+((i+3)%4)]);
        w_next[i]              = w_q[127:96];
        w_next[4+((i+1)%4)]    = w_q[95:64];
        w_next[8+((i+2)%4)]    = w_q[63:32];
        w_next[12+((i+3)%4)]   = w_q[31:0];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_nonce      <= '0;
      r_counter    <= '0;
      r_remaining  <= '0;
      r_round      <= '0;
      for (int i = 0; i < 16; i++) r_work[i] <= '0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ks_counter <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start during the done cycle is not taken.
          if (start && !r_done) begin
            if (num_blocks != '0) begin
              r_key       <= key;
              r_nonce     <= nonce;
              r_counter   <= init_counter;
              r_remaining <= num_blocks - CNT_W'(1);
              r_ovf       <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          for (int i = 0; i < 16; i++) r_work[i] <= w_init[i];
          r_round <= '0;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          for (int i = 0; i < 16; i++) r_work[i] <= w_next[i];
          if (r_round == RW'(ROUNDS - 1)) begin
            r_state <= S_ADD;
          end else begin
            r_round <= r_round + RW'(1);
          end
        end
        S_ADD: begin
          for (int i = 0; i < 16; i++) r_data[32*i +: 32] <= r_work[i] + w_init[i];
          r_ks_counter <= r_counter;
          r_valid      <= 1'b1;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (ks_ready) begin
            r_valid <= 1'b0;
            if (r_remaining == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_counter == 32'hFFFFFFFF) begin
              r_ovf   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_counter   <= r_counter + 32'd1;
              r_remaining <= r_remaining - CNT_W'(1);
              r_state     <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign ks_valid     = r_valid;
  assign ks_data      = r_data;
  assign ks_counter   = r_ks_counter;
  assign done         = r_done;
  assign ctr_overflow = r_ovf;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_chacha_keystream_engine.sv
// Bench for chacha_keystream_engine: RFC 8439 block vector, multi-block runs,
// backpressure, counter overflow, ignored/empty requests, asynchronous reset
// and a ChaCha8 build.
module tb_chacha_keystream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, start8, ks_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  init_counter;
  logic [7:0]   num_blocks;

  logic         busy, ks_valid, done, ctr_overflow;
  logic [511:0] ks_data;
  logic [31:0]  ks_counter;
  logic [2:0]   dbg_state;

  logic         busy8, ks_valid8, done8, ctr_overflow8;
  logic [511:0] ks_data8;
  logic [31:0]  ks_counter8;
  logic [2:0]   dbg_state8;

  chacha_keystream_engine #(.ROUNDS(20), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
    .init_counter(init_counter), .num_blocks(num_blocks), .busy(busy),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .ks_counter(ks_counter), .done(done), .ctr_overflow(ctr_overflow),
    .dbg_state(dbg_state)
  );

  chacha_keystream_engine #(.ROUNDS(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .key(key), .nonce(nonce),
    .init_counter(init_counter), .num_blocks(num_blocks), .busy(busy8),
    .ks_valid(ks_valid8), .ks_ready(1'b1), .ks_data(ks_data8),
    .ks_counter(ks_counter8), .done(done8), .ctr_overflow(ctr_overflow8),
    .dbg_state(dbg_state8)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit exp_ovf = 1'b0;

  logic [511:0] exp_q[$];
  logic [31:0]  exp_ctr_q[$];

  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  logic [511:0] rfc_blk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference ChaCha block function.
  function automatic logic [127:0] tqr(input logic [31:0] a0, input logic [31:0] b0,
                                       input logic [31:0] c0, input logic [31:0] d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n,
                                         input logic [31:0] c, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int r = 0; r < rounds; r += 2) begin
      {x[0], x[4], x[8],  x[12]} = tqr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = tqr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = tqr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = tqr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = tqr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = tqr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = tqr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = tqr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  // Monitor: every presented block is checked against the queue head each
  // cycle (so a stalled block must stay equal to it); popped on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (ks_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {511'b0, ks_valid}, 512'b0);
        end else begin
          chk("ks_data", ks_data, exp_q[0]);
          chk("ks_counter", {480'b0, ks_counter}, {480'b0, exp_ctr_q[0]});
          if (ks_ready) begin
            void'(exp_q.pop_front());
            void'(exp_ctr_q.pop_front());
          end
        end
      end
    end
  end

  // Issue a request and push the blocks it should produce.
  task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                       input logic [7:0] nb, input bit rfc_first);
    logic [31:0] cc;
    cc = c;
    exp_ovf = 1'b0;
    key = k; nonce = n; init_counter = c; num_blocks = nb; start = 1'b1;
    for (int b = 0; b < int'(nb); b++) begin
      if (b == 0 && rfc_first) exp_q.push_back(rfc_blk);
      else exp_q.push_back(model(k, n, cc, 20));
      exp_ctr_q.push_back(cc);
      if (b == int'(nb) - 1) break;
      if (cc == 32'hFFFFFFFF) begin
        exp_ovf = 1'b1;
        break;
      end
      cc = cc + 32'd1;
    end
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!ks_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, {511'b0, seen}, 512'd1);
    chk({nm, "_busy_low"}, {511'b0, busy}, 512'd0);
    chk({nm, "_ovf"}, {511'b0, ctr_overflow}, {511'b0, exp_ovf});
    chk({nm, "_all_blocks"}, 512'(exp_q.size()), 512'd0);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {511'b0, done}, 512'd0);
    exp_done++;
    chk({nm, "_done_count"}, 512'(done_cnt), 512'(exp_done));
  endtask

  initial begin
    int cyc;
    logic [31:0] w [16];
    w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
          32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
          32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
          32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
    for (int i = 0; i < 16; i++) rfc_blk[32*i +: 32] = w[i];
    for (int i = 0; i < 8; i++)
      rfc_key[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    // clock/reset
    rst = 1'b1; start = 1'b0; start8 = 1'b0; ks_ready = 1'b1;
    key = '0; nonce = '0; init_counter = '0; num_blocks = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {511'b0, busy}, 512'd0);
    chk("reset_valid", {511'b0, ks_valid}, 512'd0);
    chk("reset_data", ks_data, 512'd0);
    chk("reset_done", {511'b0, done}, 512'd0);
    chk("reset_state", {509'b0, dbg_state}, 512'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // RFC 8439 single block, latency 22
    issue(rfc_key, rfc_nonce, 32'd1, 8'd1, 1'b1);
    chk("t1_busy_at_accept", {511'b0, busy}, 512'd1);
    wait_valid(cyc);
    chk("t1_latency", 512'(cyc), 512'd22);
    wait_done("t1", 40);

    // three blocks, 5-cycle stall on block 2
    issue(rfc_key, rfc_nonce, 32'd1, 8'd3, 1'b1);
    wait_valid(cyc);
    @(posedge clk); #1 ks_ready = 1'b0;
    wait_valid(cyc);
    chk("t2_period", 512'(cyc), 512'd22);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_busy_stalled", {511'b0, busy}, 512'd1);
    ks_ready = 1'b1;
    wait_done("t2", 60);

    // overflow: only 0xFFFFFFFE and 0xFFFFFFFF are produced
    issue(rfc_key, rfc_nonce, 32'hFFFFFFFE, 8'd4, 1'b0);
    wait_done("t3", 100);

    // next accepted start clears the sticky flag
    issue(rfc_key, rfc_nonce, 32'd0, 8'd1, 1'b0);
    chk("t4_ovf_cleared", {511'b0, ctr_overflow}, 512'd0);
    wait_done("t4", 40);

    // start while busy (and input changes) must not disturb the request
    issue(rfc_key, rfc_nonce, 32'd5, 8'd2, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    key = ~rfc_key; nonce = ~rfc_nonce; init_counter = 32'd77; num_blocks = 8'd7;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5", 80);

    // empty request: done next edge, busy never rises; start during done ignored
    num_blocks = 8'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_done", {511'b0, done}, 512'd1);
    chk("t6_busy", {511'b0, busy}, 512'd0);
    num_blocks = 8'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_ignored_busy", {511'b0, busy}, 512'd0);
    exp_done++;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_still_idle", {511'b0, busy}, 512'd0);
    chk("t6_done_count", 512'(done_cnt), 512'(exp_done));

    // asynchronous reset mid-ROUND
    issue(rfc_key, rfc_nonce, 32'd1, 8'd3, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_busy", {511'b0, busy}, 512'd0);
    chk("t7_valid", {511'b0, ks_valid}, 512'd0);
    chk("t7_data", ks_data, 512'd0);
    chk("t7_counter", {480'b0, ks_counter}, 512'd0);
    chk("t7_state", {509'b0, dbg_state}, 512'd0);
    exp_q.delete();
    exp_ctr_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(rfc_key, rfc_nonce, 32'd1, 8'd1, 1'b1);
    wait_valid(cyc);
    chk("t7_latency", 512'(cyc), 512'd22);
    wait_done("t7", 40);

    // ChaCha8 build: latency 10, data from the reference model
    key = rfc_key; nonce = rfc_nonce; init_counter = 32'd1; num_blocks = 8'd1;
    start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    cyc = 0;
    while (!ks_valid8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t8_latency", 512'(cyc), 512'd10);
    chk("t8_data", ks_data8, model(rfc_key, rfc_nonce, 32'd1, 8));
    chk("t8_counter", {480'b0, ks_counter8}, 512'd1);
    @(posedge clk); #1;
    chk("t8_done", {511'b0, done8}, 512'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
